cia_timer_ctrl: RTL and testbench

Register-mapped controller that configures, starts, stops and reloads two `counter` instances (timer A = index 0, timer B = index 1) on behalf of the 6510 bus, in the style of the MOS 6526 timer section. It holds the 16-bit reload latches and control registers, and sequences each counter's active-low load strobe (`i_cs`) and its mode. It collects each counter's `o_irq` pulse into an interrupt flag/mask pair and drives the CPU IRQ line.

---
 rtl/cia_timer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cia_timer_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cia_timer_ctrl.sv
// Purpose: 6526-style timer-section controller for two counters: reload latches, control regs, load-strobe FSMs, ICR.
// Latency: writes take effect at the sampling edge; read data and o_irq_n are registered (visible one cycle later).
// Backpressure: none; every clock with i_cs=0 is exactly one access, and i_cnt_irq is sampled every cycle.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_cs, i_rw, i_addr,     6510-side register access (i_cs active low, i_rw 1=read)
//   i_data, o_data          write data / registered read data
//   o_irq_n                 CPU interrupt, active low, registered
//   i_cnt_irq               per-counter terminal-count pulse (bit0 = A, bit1 = B)
//   o_cnt_cs                per-counter active-low load strobe
//   o_cnt_mode              per-counter mode, 1 = continuous, 0 = single-shot
//   o_cnt_value0/1          reload values (mirror of latches A/B)
module cia_timer_ctrl #(
  parameter int TIMERS = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cs,
  input  logic              i_rw,
  input  logic [3:0]        i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_irq_n,
  input  logic [TIMERS-1:0] i_cnt_irq,
  output logic [TIMERS-1:0] o_cnt_cs,
  output logic [TIMERS-1:0] o_cnt_mode,
  output logic [15:0]       o_cnt_value0,
  output logic [15:0]       o_cnt_value1
);

  typedef enum logic [1:0] {
    TS_STOPPED = 2'd0,
    TS_LOAD    = 2'd1,
    TS_RUNNING = 2'd2
  } ts_e;

  localparam logic [3:0] ADDR_TALO = 4'h4;
  localparam logic [3:0] ADDR_TAHI = 4'h5;
  localparam logic [3:0] ADDR_TBLO = 4'h6;
  localparam logic [3:0] ADDR_TBHI = 4'h7;
  localparam logic [3:0] ADDR_ICR  = 4'hD;
  localparam logic [3:0] ADDR_CRA  = 4'hE;
  localparam logic [3:0] ADDR_CRB  = 4'hF;

  // Register state
  logic [TIMERS-1:0][15:0] latch_q, latch_d;
  logic [TIMERS-1:0]       start_q, start_d;
  logic [TIMERS-1:0]       oneshot_q, oneshot_d;
  logic [TIMERS-1:0]       mask_q, mask_d;
  logic [TIMERS-1:0]       flags_q, flags_d;
  ts_e                     state_q [TIMERS];
  ts_e                     state_d [TIMERS];
  logic [7:0]              data_q, data_d;
  logic                    irq_n_q, irq_n_d;

  // Access decode
  logic              wr_en, rd_en, icr_rd;
  logic [TIMERS-1:0] ctrl_wr;
  logic [7:0]        rd_data;

  assign wr_en      = ~i_cs & ~i_rw;
  assign rd_en      = ~i_cs &  i_rw;
  assign icr_rd     = rd_en && (i_addr == ADDR_ICR);
  assign ctrl_wr[0] = wr_en && (i_addr == ADDR_CRA);
  assign ctrl_wr[1] = wr_en && (i_addr == ADDR_CRB);

  // Latches, mask and flags
  always_comb begin
    latch_d = latch_q;
    mask_d  = mask_q;
    flags_d = flags_q;

    if (wr_en) begin
      case (i_addr)
        ADDR_TALO: latch_d[0][7:0]  = i_data;
        ADDR_TAHI: latch_d[0][15:8] = i_data;
        ADDR_TBLO: latch_d[1][7:0]  = i_data;
        ADDR_TBHI: latch_d[1][15:8] = i_data;
        ADDR_ICR: begin
          if (i_data[7]) mask_d = mask_q | i_data[TIMERS-1:0];
          else           mask_d = mask_q & ~i_data[TIMERS-1:0];
        end
        default: ;
      endcase
    end

    // The clear-on-read is applied first so a coinciding event survives it.
    if (icr_rd) flags_d = '0;
    flags_d = flags_d | i_cnt_irq;
  end

  // Per-timer control FSM
  always_comb begin
    start_d   = start_q;
    oneshot_d = oneshot_q;
    for (int i = 0; i < TIMERS; i++) begin
      state_d[i] = state_q[i];

      if (ctrl_wr[i]) begin
        // A control write always wins over a coinciding one-shot expiry.
        start_d[i]   = i_data[0];
        oneshot_d[i] = i_data[3];
        if (!i_data[0]) begin
          state_d[i] = TS_STOPPED;
        end else if (state_q[i] == TS_STOPPED) begin
          // Counter was already loading while stopped; FORCELOAD adds nothing.
          state_d[i] = TS_RUNNING;
        end else if (i_data[4]) begin
          state_d[i] = TS_LOAD;
        end else begin
          state_d[i] = TS_RUNNING;
        end
      end else begin
        case (state_q[i])
          TS_LOAD: state_d[i] = TS_RUNNING;
          TS_RUNNING: begin
            if (i_cnt_irq[i] && oneshot_q[i]) begin
              start_d[i] = 1'b0;
              state_d[i] = TS_STOPPED;
            end
          end
          default: state_d[i] = TS_STOPPED;
        endcase
      end
    end
  end

  // Read mux and registered outputs
  always_comb begin
    rd_data = 8'h00;
    case (i_addr)
      ADDR_TALO: rd_data = latch_q[0][7:0];
      ADDR_TAHI: rd_data = latch_q[0][15:8];
      ADDR_TBLO: rd_data = latch_q[1][7:0];
      ADDR_TBHI: rd_data = latch_q[1][15:8];
      ADDR_ICR:  rd_data = {|(flags_q & mask_q), 5'b0, flags_q};
      ADDR_CRA:  rd_data = {4'b0, 1'b0, oneshot_q[0], 2'b0, start_q[0]};
      ADDR_CRB:  rd_data = {4'b0, 1'b0, oneshot_q[1], 2'b0, start_q[1]};
      default:   rd_data = 8'h00;
    endcase

    data_d  = rd_en ? rd_data : data_q;
    irq_n_d = ~|(flags_q & mask_q);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      latch_q   <= {TIMERS{16'hFFFF}};
      start_q   <= '0;
      oneshot_q <= '0;
      mask_q    <= '0;
      flags_q   <= '0;
      data_q    <= 8'h00;
      irq_n_q   <= 1'b1;
      for (int i = 0; i < TIMERS; i++) state_q[i] <= TS_STOPPED;
    end else begin
      latch_q   <= latch_d;
      start_q   <= start_d;
      oneshot_q <= oneshot_d;
      mask_q    <= mask_d;
      flags_q   <= flags_d;
      data_q    <= data_d;
      irq_n_q   <= irq_n_d;
      for (int i = 0; i < TIMERS; i++) state_q[i] <= state_d[i];
    end
  end

  // Counter is only released to decrement in the running state.
  always_comb begin
    for (int i = 0; i < TIMERS; i++) o_cnt_cs[i] = (state_q[i] == TS_RUNNING);
  end

  assign o_cnt_mode   = ~oneshot_q;
  assign o_cnt_value0 = latch_q[0];
  assign o_cnt_value1 = latch_q[1];
  assign o_data       = data_q;
  assign o_irq_n      = irq_n_q;

endmodule

// File: tb/tb_cia_timer_ctrl.sv
// Purpose: directed bench for cia_timer_ctrl; read results are checked through an expected-value queue.
// Latency: inputs change 1 ns after the rising edge, outputs are sampled at the same point.
// Backpressure: none; the bench runs a fixed number of cycles.
module tb_cia_timer_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cs;
  logic        i_rw;
  logic [3:0]  i_addr;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        o_irq_n;
  logic [1:0]  i_cnt_irq;
  logic [1:0]  o_cnt_cs;
  logic [1:0]  o_cnt_mode;
  logic [15:0] o_cnt_value0;
  logic [15:0] o_cnt_value1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  always #5 i_clk = ~i_clk;

  cia_timer_ctrl #(.TIMERS(2)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_cs         (i_cs),
    .i_rw         (i_rw),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_irq_n      (o_irq_n),
    .i_cnt_irq    (i_cnt_irq),
    .o_cnt_cs     (o_cnt_cs),
    .o_cnt_mode   (o_cnt_mode),
    .o_cnt_value0 (o_cnt_value0),
    .o_cnt_value1 (o_cnt_value1)
  );

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    i_cs = 1'b0; i_rw = 1'b0; i_addr = addr; i_data = data;
    cyc();
    i_cs = 1'b1; i_rw = 1'b1;
  endtask

  // Issue a read (optionally with counter irq pulses in the same cycle),
  // queue its expected data, then pop and compare once o_data is valid.
  task automatic rd(input logic [3:0] addr, input logic [7:0] exp, input string tag,
                    input logic [1:0] irq = 2'b00);
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    i_cs = 1'b0; i_rw = 1'b1; i_addr = addr; i_cnt_irq = irq;
    cyc();
    i_cs = 1'b1; i_cnt_irq = 2'b00;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {8'h00, o_data}, {8'h00, e});
  endtask

  task automatic pulse_irq(input logic [1:0] irq);
    i_cnt_irq = irq;
    cyc();
    i_cnt_irq = 2'b00;
  endtask

  initial begin
    i_reset = 1'b1; i_cs = 1'b1; i_rw = 1'b1; i_addr = 4'h0; i_data = 8'h00; i_cnt_irq = 2'b00;
    #1;
    chk("rst_cnt_cs",  {14'h0, o_cnt_cs},   16'h0000);
    chk("rst_mode",    {14'h0, o_cnt_mode}, 16'h0003);
    chk("rst_value0",  o_cnt_value0,        16'hFFFF);
    chk("rst_value1",  o_cnt_value1,        16'hFFFF);
    chk("rst_data",    {8'h00, o_data},     16'h0000);
    chk("rst_irq_n",   {15'h0, o_irq_n},    16'h0001);
    cyc(); cyc();
    i_reset = 1'b0;
    cyc();

    // Continuous run on timer A
    wr(4'h4, 8'h03);
    wr(4'h5, 8'h00);
    chk("cont_value0", o_cnt_value0, 16'h0003);
    wr(4'hD, 8'h81);
    chk("cont_cs_before", {14'h0, o_cnt_cs}, 16'h0000);
    wr(4'hE, 8'h01);
    chk("cont_cs_run", {14'h0, o_cnt_cs}, 16'h0001);
    chk("cont_mode",   {14'h0, o_cnt_mode}, 16'h0003);
    rd(4'h4, 8'h03, "cont_talo");
    rd(4'h5, 8'h00, "cont_tahi");
    pulse_irq(2'b01);
    chk("cont_irq_n_lat", {15'h0, o_irq_n}, 16'h0001);
    cyc();
    chk("cont_irq_n_low", {15'h0, o_irq_n}, 16'h0000);
    rd(4'hD, 8'h81, "cont_icr1");
    chk("cont_irq_n_hold", {15'h0, o_irq_n}, 16'h0000);
    cyc();
    chk("cont_irq_n_clr", {15'h0, o_irq_n}, 16'h0001);
    rd(4'hD, 8'h00, "cont_icr2");

    // One-shot on timer B (mask B clear)
    wr(4'hF, 8'h09);
    chk("os_cs_run", {14'h0, o_cnt_cs}, 16'h0003);
    chk("os_mode",   {14'h0, o_cnt_mode}, 16'h0001);
    rd(4'hF, 8'h09, "os_crb_run");
    pulse_irq(2'b10);
    chk("os_cs_stop", {14'h0, o_cnt_cs}, 16'h0001);
    rd(4'hF, 8'h08, "os_crb_stop");
    cyc();
    chk("os_irq_n", {15'h0, o_irq_n}, 16'h0001);
    rd(4'hD, 8'h02, "os_icr");

    // Force load on running timer A
    wr(4'hE, 8'h11);
    chk("fl_cs_load", {14'h0, o_cnt_cs}, 16'h0000);
    cyc();
    chk("fl_cs_run", {14'h0, o_cnt_cs}, 16'h0001);
    rd(4'hE, 8'h01, "fl_cra");

    // Read racing a timer A event, mask A set
    rd(4'hD, 8'h00, "race_icr_old", 2'b01);
    rd(4'hD, 8'h81, "race_icr_new");
    // Same with mask A cleared
    wr(4'hD, 8'h01);
    rd(4'hD, 8'h00, "race2_icr_old", 2'b01);
    rd(4'hD, 8'h01, "race2_icr_new");

    // Stop timer A, latch writes then propagate straight through
    wr(4'hE, 8'h00);
    chk("stop_cs", {14'h0, o_cnt_cs}, 16'h0000);
    wr(4'h4, 8'h55);
    chk("stop_value0", o_cnt_value0, 16'h0055);
    wr(4'hE, 8'h10);
    chk("stop_fl_cs", {14'h0, o_cnt_cs}, 16'h0000);
    rd(4'hE, 8'h00, "stop_fl_cra");

    // Control write coinciding with one-shot expiry: written START=1 wins
    wr(4'hE, 8'h09);
    i_cnt_irq = 2'b01;
    wr(4'hE, 8'h01);
    i_cnt_irq = 2'b00;
    chk("conf_cs", {14'h0, o_cnt_cs}, 16'h0001);
    rd(4'hE, 8'h01, "conf_cra");
    rd(4'hD, 8'h01, "conf_icr");

    // Unlisted address and timer B latch
    wr(4'h2, 8'hAA);
    rd(4'h2, 8'h00, "unlisted");
    wr(4'h7, 8'h12);
    chk("tb_value1", o_cnt_value1, 16'h12FF);

    // Asynchronous reset mid-run with IRQ asserted
    wr(4'hD, 8'h81);
    pulse_irq(2'b01);
    cyc();
    chk("pre_rst_irq_n", {15'h0, o_irq_n}, 16'h0000);
    #2;
    i_reset = 1'b1;
    #1;
    chk("mid_rst_cs",     {14'h0, o_cnt_cs}, 16'h0000);
    chk("mid_rst_irq_n",  {15'h0, o_irq_n},  16'h0001);
    chk("mid_rst_value0", o_cnt_value0,      16'hFFFF);
    cyc();
    i_reset = 1'b0;
    cyc();
    rd(4'h5, 8'hFF, "post_rst_tahi");
    rd(4'hE, 8'h00, "post_rst_cra");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
